// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, SPI mode encodings and a width helper
// for the burst SPI reader.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, STALL, FINISH} state_t;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period counter; tick strobes once every div+1 enabled
// cycles, load restarts the count.
module spi_sclk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && cnt == div;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load || tick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;

endmodule

// File: rtl/spi_read_burst.sv
// spi_read_burst: SPI master reading a burst of DATA_W-bit words with runtime
// mode/divider, delivering each word on a valid/ready stream.
module spi_read_burst import spi_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter int CNT_W     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CNT_W-1:0]  len,
    input  logic              start,
    input  logic              abort,
    output logic              spi_sclk,
    input  logic              spi_miso,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int BW = clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t state, state_n;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] len_q, wcnt;
    logic [BW-1:0] bcnt;
    logic [DATA_W-1:0] sreg, word_nx;
    logic cpol_q, cpha_q, ph;
    logic tick, go, accept, free, samp, word_end, last_word, load_out;

    spi_sclk_div #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (state == IDLE || state == STALL),
        .en   (state == LEAD || state == SHIFT),
        .div  (div_q),
        .tick (tick)
    );

    assign go        = state == IDLE && start && !abort;
    assign accept    = valid && ready;
    assign free      = !valid || ready;
    assign samp      = state == SHIFT && tick && ph == cpha_q;
    assign word_end  = state == SHIFT && tick && ph && bcnt == LAST_BIT;
    assign last_word = wcnt == len_q - 1'b1;
    assign load_out  = !abort && ((word_end && free) || (state == STALL && accept));
    // the completing edge may itself be a sampling edge (cpha=1), so deliver word_nx
    assign word_nx   = !samp ? sreg :
                       MSB_FIRST ? {sreg[DATA_W-2:0], spi_miso} : {spi_miso, sreg[DATA_W-1:1]};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = LEAD;
            LEAD:    if (tick) state_n = SHIFT;
            SHIFT:   if (word_end) state_n = !free ? STALL : last_word ? FINISH : SHIFT;
            STALL:   if (accept) state_n = last_word ? FINISH : SHIFT;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state inside {LEAD, SHIFT, STALL}) state_n = FINISH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            spi_sclk <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_q    <= '0;
            len_q    <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            sreg     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            ph       <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= state_n != IDLE;
            done     <= state_n == FINISH;
            spi_sclk <= go ? cpol : (state == SHIFT && !abort) ? spi_sclk ^ tick : cpol_q;
            valid    <= load_out || (valid && !ready);
            if (go) begin
                div_q  <= div;
                cpol_q <= cpol;
                cpha_q <= cpha;
                len_q  <= len == '0 ? CNT_W'(1) : len;
                wcnt   <= '0;
                bcnt   <= '0;
                sreg   <= '0;
                ph     <= 1'b0;
            end
            if (state == SHIFT && tick) begin
                ph   <= !ph;
                sreg <= word_nx;
                if (ph) bcnt <= bcnt == LAST_BIT ? '0 : bcnt + 1'b1;
            end
            if (load_out) begin
                data <= state == STALL ? sreg : word_nx;
                wcnt <= wcnt + 1'b1;
            end
        end
    end

endmodule
